conv2d_stream: RTL
==================

# conv2d_stream

Streaming 2-D convolution engine for the CNN/edge-detection pipeline. Accepts one pixel per cycle in raster order over a valid/ready handshake and emits one output pixel per fully-populated KERNEL_DIM×KERNEL_DIM window, with no padding. It generalises the fixed 3×3 Laplacian stage in three ways: runtime-loadable signed coefficients, selectable output mode, and full backpressure support. It sits between the pixel source (camera/DMA stream) and downstream CNN layers.

## Interface
Parameters:
- WORD_SIZE, 8: pixel width, unsigned.
- ROW_SIZE, 540: pixels per image row.
- KERNEL_DIM, 3: odd kernel size, legal values 3, 5, 7.
- COEF_WIDTH, 8: signed coefficient width.
- SHIFT_WIDTH, 4: width of the normalisation shift control.

Ports:
- clk  in  1: single clock domain.
- rst_n  in  1: reset, asynchronous assert, active-low.
- in_valid  in  1: in_pixel is valid.
- in_ready  out  1: block can accept a pixel this cycle.
- in_pixel  in  WORD_SIZE: input pixel, raster order.
- in_sof  in  1: start of frame; qualified by in_valid && in_ready.
- coef_we  in  1: coefficient write strobe.
- coef_addr  in  $clog2(KERNEL_DIM*KERNEL_DIM): row-major index r*KERNEL_DIM+c. r=0 is the oldest row; c=0 is the oldest column.
- coef_data  in  COEF_WIDTH: signed coefficient.
- mode  in  1: 0 = clamp negatives to 0; 1 = absolute value.
- shift  in  SHIFT_WIDTH: arithmetic right shift applied to the sum.
- out_valid  out  1: out_pixel is valid.
- out_ready  in  1: downstream accepts.
- out_pixel  out  WORD_SIZE: result pixel.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Global stall: advance = !out_valid || out_ready. in_ready = advance. All pipeline stages hold when advance is low.
- Counters (update on input transfer only):
  - col counts 0..ROW_SIZE-1 and wraps to 0.
  - row counts up and saturates at KERNEL_DIM-1; it increments when col wraps.
- in_sof on a transfer forces that pixel to col=0, row=0. Any partial window is discarded. Results already in flight still drain.
- Window valid (wv) for the accepted pixel: row==KERNEL_DIM-1 && col>=KERNEL_DIM-1. Columns 0..KERNEL_DIM-2 of each row advance the line buffer but produce no output.
- Outputs per H-row frame: (H-KERNEL_DIM+1)*(ROW_SIZE-KERNEL_DIM+1).
- Arithmetic:
  - Each product is the zero-extended pixel times the signed coefficient, width WORD_SIZE+COEF_WIDTH+1.
  - The sum adds $clog2(K*K) guard bits.
  - The sum is arithmetic-right-shifted by shift.
- Output mode:
  - mode 0: values <0 become 0; values >2^WORD_SIZE-1 become 2^WORD_SIZE-1.
  - mode 1: take |x|, then saturate to 2^WORD_SIZE-1.
- Coefficients:
  - Reset to the Laplacian: centre = K*K-1, all others = -1.
  - coef_we writes coefficient[coef_addr] on the next edge, independent of stall.
  - A write takes effect for products computed after that edge. Software writes only between frames.
- mode and shift are quasi-static, sampled at the normalisation stage. Changing them mid-frame affects only later outputs.

## Timing
- Pipeline stages:
  - S1: window capture.
  - S2: products.
  - S3: adder tree plus shift.
  - S4: mode/saturate into the out_pixel register.
- Latency is 4 advancing cycles from the input transfer that completes a window to out_valid.
- Throughput is 1 pixel/cycle when out_ready stays high.
- A per-stage valid bit travels with the data. out_valid is the S4 valid bit.
- out_pixel and out_valid hold stable while out_valid && !out_ready.
- Reset values (rst_n low, asynchronous): out_valid=0, out_pixel=0, col=0, row=0, all stage valid bits 0, coefficients = Laplacian. in_ready=1 from the first edge after release.
- Line buffer contents are not reset; stage valid bits mask them.
- Reset mid-frame: the frame is lost. The next accepted pixel is treated as col=0, row=0 whether or not in_sof is set.
- If in_sof and a column wrap occur on the same transfer, in_sof wins.

## Structure
- Package conv_pkg:
  - Function producing the default Laplacian coefficient array.
  - Product and sum width localparams derived from WORD_SIZE, COEF_WIDTH and KERNEL_DIM.
  - Mode enum: MODE_CLAMP, MODE_ABS.
- Sub-module conv_line_buffer:
  - Shift register of depth ROW_SIZE*(KERNEL_DIM-1)+KERNEL_DIM, enabled on input transfer.
  - Exposes the KERNEL_DIM×KERNEL_DIM tap array.
- The top level holds the counters, coefficient RAM, arithmetic pipeline and handshake.

## Test plan
- Reset defaults; ROW_SIZE=8, K=3; flat 8×8 frame of value 50 → exactly 36 outputs, all 0. First out_valid appears 4 cycles after pixel index 18 is accepted.
- Single pixel 100 in a 0 field, default kernel:
  - mode 0 → centre output 255, its 8 neighbours 0.
  - mode 1 → neighbours 100.
- Load identity (centre=1, others=0), shift=0, ramp input → output equals input at (r,c) for r,c≥1, in raster order.
- Load all-ones, shift=3, flat 80 → every output 90 (720>>3).
- Random out_ready at 50% duty → the output sequence is identical to the no-stall run. out_pixel never changes while stalled. No pixel is lost.
- in_sof asserted mid-row, then a new frame → no outputs until 2 rows + 3 pixels of the new frame have been accepted. Output count for the new frame is correct.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the streaming 2-D convolution engine.
// Widths are functions so each instance derives them from its own parameters.
package conv_pkg;

  typedef enum logic {
    MODE_CLAMP = 1'b0,
    MODE_ABS   = 1'b1
  } mode_e;

  function automatic int prod_width(input int word_size, input int coef_width);
    return word_size + coef_width + 1;
  endfunction

  function automatic int sum_width(input int word_size, input int coef_width,
                                   input int kernel_dim);
    return prod_width(word_size, coef_width) + $clog2(kernel_dim * kernel_dim);
  endfunction

  // Laplacian: centre tap K*K-1, every other tap -1.
  function automatic int laplace_coef(input int idx, input int kernel_dim);
    return (idx == (kernel_dim * kernel_dim) / 2) ? kernel_dim * kernel_dim - 1 : -1;
  endfunction

  localparam int PROD_W_DEFAULT = prod_width(8, 8);
  localparam int SUM_W_DEFAULT  = sum_width(8, 8, 3);

endpackage

// File: rtl/conv_line_buffer.sv
// Raster line buffer exposing the KxK window ending at the newest pixel; shifts only on
// an accepted input, so it holds whenever the pipeline stalls. Contents are not reset.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 540,
  parameter int KERNEL_DIM = 3
) (
  input  logic                 clk,
  input  logic                 shift_en_i,
  input  logic [WORD_SIZE-1:0] pixel_i,
  output logic [WORD_SIZE-1:0] taps_o [KERNEL_DIM*KERNEL_DIM]
);

  localparam int DEPTH = ROW_SIZE * (KERNEL_DIM - 1) + KERNEL_DIM;

  logic [WORD_SIZE-1:0] sr_q [DEPTH];
  logic [WORD_SIZE-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = pixel_i;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (shift_en_i) sr_q <= sr_d;
  end

  // Tap (r,c): r=0 oldest row, c=0 oldest column; sr_q[0] is the newest pixel.
  always_comb begin
    for (int r = 0; r < KERNEL_DIM; r++) begin
      for (int c = 0; c < KERNEL_DIM; c++) begin
        taps_o[r*KERNEL_DIM + c] = sr_q[(KERNEL_DIM-1-r)*ROW_SIZE + (KERNEL_DIM-1-c)];
      end
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution, one pixel/cycle; result 4 advancing cycles after the window's
// last pixel. A single global stall (advance) freezes every stage while out_valid && !out_ready.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int WORD_SIZE   = 8,
  parameter int ROW_SIZE    = 540,
  parameter int KERNEL_DIM  = 3,
  parameter int COEF_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [WORD_SIZE-1:0]                       in_pixel,
  input  logic                                       in_sof,
  input  logic                                       coef_we,
  input  logic [$clog2(KERNEL_DIM*KERNEL_DIM)-1:0]   coef_addr,
  input  logic [COEF_WIDTH-1:0]                      coef_data,
  input  logic                                       mode,
  input  logic [SHIFT_WIDTH-1:0]                     shift,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [WORD_SIZE-1:0]                       out_pixel
);

  localparam int NTAP = KERNEL_DIM * KERNEL_DIM;
  localparam int PW   = prod_width(WORD_SIZE, COEF_WIDTH);
  localparam int SW   = sum_width(WORD_SIZE, COEF_WIDTH, KERNEL_DIM);
  localparam int CW   = $clog2(ROW_SIZE);
  localparam int RW   = $clog2(KERNEL_DIM);

  logic                 advance, xfer, wv;
  logic [CW-1:0]        col_q, col_d, cur_col;
  logic [RW-1:0]        row_q, row_d, cur_row;
  logic [WORD_SIZE-1:0] taps [NTAP];

  logic signed [COEF_WIDTH-1:0] coef_q [NTAP];
  logic signed [PW-1:0]         prod_q [NTAP];
  logic signed [PW-1:0]         prod_d [NTAP];
  logic signed [SW-1:0]         sum_d, s3_q, s3_d;
  logic [SW-1:0]                mag;
  logic [WORD_SIZE-1:0]         norm_d, out_pixel_q;
  logic                         s1_vld_q, s2_vld_q, s3_vld_q, out_valid_q;
  mode_e                        mode_sel;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign xfer      = in_valid && advance;
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign mode_sel  = mode_e'(mode);

  // A start-of-frame pixel is position (0,0) regardless of where the counters were.
  assign cur_col = in_sof ? '0 : col_q;
  assign cur_row = in_sof ? '0 : row_q;
  assign wv      = (cur_row == RW'(KERNEL_DIM-1)) && (cur_col >= CW'(KERNEL_DIM-1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (xfer) begin
      if (cur_col == CW'(ROW_SIZE-1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(KERNEL_DIM-1)) ? cur_row : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  conv_line_buffer #(
    .WORD_SIZE (WORD_SIZE),
    .ROW_SIZE  (ROW_SIZE),
    .KERNEL_DIM(KERNEL_DIM)
  ) u_line_buffer (
    .clk       (clk),
    .shift_en_i(xfer),
    .pixel_i   (in_pixel),
    .taps_o    (taps)
  );

  always_comb begin
    for (int i = 0; i < NTAP; i++) begin
      prod_d[i] = PW'($signed({1'b0, taps[i]})) * PW'(coef_q[i]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NTAP; i++) sum_d = sum_d + SW'(prod_q[i]);
    s3_d = sum_d >>> shift;
  end

  // Magnitude is taken unsigned so the most negative sum still saturates correctly.
  always_comb begin
    mag    = s3_q[SW-1] ? $unsigned(-s3_q) : $unsigned(s3_q);
    norm_d = s3_q[WORD_SIZE-1:0];
    if (mode_sel == MODE_ABS) begin
      norm_d = (|mag[SW-1:WORD_SIZE]) ? '1 : mag[WORD_SIZE-1:0];
    end else if (s3_q[SW-1]) begin
      norm_d = '0;
    end else if (|s3_q[SW-1:WORD_SIZE]) begin
      norm_d = '1;
    end
  end

  // Coefficient writes ignore the stall so software can load while the stream is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAP; i++) coef_q[i] <= COEF_WIDTH'(laplace_coef(i, KERNEL_DIM));
    end else if (coef_we) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s3_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      prod_q      <= '{default: '0};
      s3_q        <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (advance) begin
        s1_vld_q    <= xfer && wv;
        s2_vld_q    <= s1_vld_q;
        s3_vld_q    <= s2_vld_q;
        out_valid_q <= s3_vld_q;
        prod_q      <= prod_d;
        s3_q        <= s3_d;
        if (s3_vld_q) out_pixel_q <= norm_d;
      end
    end
  end

endmodule
